// File: rtl/decode_stage_hz.sv
// RV32I/RV32E decode stage: register file with optional write-back bypass,
// control/immediate decode and a hazard-aware D/E pipeline register.
module decode_stage_hz #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int WB_BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            ValidD,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic            RegWriteW,
    input  logic [4:0]      RDW,
    input  logic [XLEN-1:0] ResultW,
    output logic [4:0]      RS1_D,
    output logic [4:0]      RS2_D,
    output logic            RegWriteE,
    output logic            ALUSrcE,
    output logic            MemWriteE,
    output logic            BranchE,
    output logic            JumpE,
    output logic            JalrE,
    output logic [1:0]      ResultSrcE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1_E,
    output logic [XLEN-1:0] RD2_E,
    output logic [XLEN-1:0] Imm_Ext_E,
    output logic [4:0]      RD_E,
    output logic [4:0]      RS1_E,
    output logic [4:0]      RS2_E,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic            ValidE,
    output logic            IllegalE
);

    localparam int RAW = $clog2(NREGS);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BRNCH = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_PASS = 3'b110;

    typedef struct packed {
        logic            reg_write;
        logic            alu_src;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic            jalr;
        logic [1:0]      result_src;
        logic [2:0]      alu_ctrl;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic            valid;
        logic            illegal;
    } de_t;

    function automatic logic in_range(input logic [4:0] idx);
        return {1'b0, idx} < 6'(NREGS);
    endfunction

    logic [XLEN-1:0] regs [NREGS];
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rs1, rs2, rd;
    logic            wr_en;
    logic [XLEN-1:0] rd1, rd2;
    logic [31:0]     imm32;
    de_t             d_next, e_q;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign rd     = InstrD[11:7];
    assign rs1    = InstrD[19:15];
    assign rs2    = InstrD[24:20];
    assign RS1_D  = rs1;
    assign RS2_D  = rs2;
    assign wr_en  = RegWriteW && (RDW != 5'd0) && in_range(RDW);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[RDW[RAW-1:0]] <= ResultW;
        end
    end

    // x0 and out-of-range indices read as zero; bypass only on a live write
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs1 != 5'd0 && in_range(rs1)) begin
            if (WB_BYPASS != 0 && wr_en && RDW == rs1) rd1 = ResultW;
            else                                        rd1 = regs[rs1[RAW-1:0]];
        end
        if (rs2 != 5'd0 && in_range(rs2)) begin
            if (WB_BYPASS != 0 && wr_en && RDW == rs2) rd2 = ResultW;
            else                                        rd2 = regs[rs2[RAW-1:0]];
        end
    end

    always_comb begin
        logic [2:0] alu_op;
        logic       known;
        logic       use_rs1, use_rs2, use_rd;
        logic       bad_reg;

        d_next   = '0;
        imm32    = '0;
        known    = 1'b1;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        use_rd   = 1'b0;

        unique case (funct3)
            3'b111:  alu_op = ALU_AND;
            3'b110:  alu_op = ALU_OR;
            3'b010:  alu_op = ALU_SLT;
            default: alu_op = ALU_ADD;
        endcase

        case (opcode)
            OP_LOAD: begin
                d_next.reg_write  = 1'b1;
                d_next.alu_src    = 1'b1;
                d_next.result_src = 2'b01;
                imm32 = {{20{InstrD[31]}}, InstrD[31:20]};
                {use_rs1, use_rd} = 2'b11;
            end
            OP_STORE: begin
                d_next.mem_write = 1'b1;
                d_next.alu_src   = 1'b1;
                imm32 = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
                {use_rs1, use_rs2} = 2'b11;
            end
            OP_R: begin
                d_next.reg_write = 1'b1;
                d_next.alu_ctrl  = (funct3 == 3'b000 && InstrD[30]) ? ALU_SUB : alu_op;
                {use_rs1, use_rs2, use_rd} = 3'b111;
            end
            OP_I: begin
                d_next.reg_write = 1'b1;
                d_next.alu_src   = 1'b1;
                d_next.alu_ctrl  = alu_op;
                imm32 = {{20{InstrD[31]}}, InstrD[31:20]};
                {use_rs1, use_rd} = 2'b11;
            end
            OP_BRNCH: begin
                d_next.branch   = 1'b1;
                d_next.alu_ctrl = ALU_SUB;
                imm32 = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25],
                         InstrD[11:8], 1'b0};
                {use_rs1, use_rs2} = 2'b11;
            end
            OP_JAL: begin
                d_next.reg_write  = 1'b1;
                d_next.jump       = 1'b1;
                d_next.result_src = 2'b10;
                imm32 = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20],
                         InstrD[30:21], 1'b0};
                use_rd = 1'b1;
            end
            OP_JALR: begin
                d_next.reg_write  = 1'b1;
                d_next.jalr       = 1'b1;
                d_next.alu_src    = 1'b1;
                d_next.result_src = 2'b10;
                imm32 = {{20{InstrD[31]}}, InstrD[31:20]};
                {use_rs1, use_rd} = 2'b11;
            end
            OP_LUI: begin
                d_next.reg_write = 1'b1;
                d_next.alu_src   = 1'b1;
                d_next.alu_ctrl  = ALU_PASS;
                imm32 = {InstrD[31:12], 12'b0};
                use_rd = 1'b1;
            end
            default: known = 1'b0;
        endcase

        bad_reg = (use_rs1 && !in_range(rs1)) || (use_rs2 && !in_range(rs2)) ||
                  (use_rd && !in_range(rd));

        d_next.illegal = ValidD && (!known || bad_reg);
        // Bubbles and illegal instructions must not cause any side effects in E
        if (!ValidD || d_next.illegal) begin
            d_next.reg_write  = 1'b0;
            d_next.alu_src    = 1'b0;
            d_next.mem_write  = 1'b0;
            d_next.branch     = 1'b0;
            d_next.jump       = 1'b0;
            d_next.jalr       = 1'b0;
            d_next.result_src = 2'b00;
            d_next.alu_ctrl   = 3'b000;
        end

        d_next.imm   = XLEN'($signed(imm32));
        d_next.rd1   = rd1;
        d_next.rd2   = rd2;
        d_next.rd    = rd;
        d_next.rs1   = rs1;
        d_next.rs2   = rs2;
        d_next.pc    = PCD;
        d_next.pc4   = PCPlus4D;
        d_next.valid = ValidD;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         e_q <= '0;
        else if (FlushE)  e_q <= '0;
        else if (!StallE) e_q <= d_next;
    end

    assign RegWriteE   = e_q.reg_write;
    assign ALUSrcE     = e_q.alu_src;
    assign MemWriteE   = e_q.mem_write;
    assign BranchE     = e_q.branch;
    assign JumpE       = e_q.jump;
    assign JalrE       = e_q.jalr;
    assign ResultSrcE  = e_q.result_src;
    assign ALUControlE = e_q.alu_ctrl;
    assign RD1_E       = e_q.rd1;
    assign RD2_E       = e_q.rd2;
    assign Imm_Ext_E   = e_q.imm;
    assign RD_E        = e_q.rd;
    assign RS1_E       = e_q.rs1;
    assign RS2_E       = e_q.rs2;
    assign PCE         = e_q.pc;
    assign PCPlus4E    = e_q.pc4;
    assign ValidE      = e_q.valid;
    assign IllegalE    = e_q.illegal;

endmodule
